// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and data-memory access bundle for lsu_ctrl.
// slave = the load/store unit, master = pipeline plus data memory.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] dm_addr;
  logic [2:0]        dm_re;
  logic [1:0]        dm_wr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  modport slave (
    input  req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dm_addr, dm_re, dm_wr, dm_wdata
  );

  modport master (
    output req_valid, req_wr, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dm_addr, dm_re, dm_wr, dm_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store initiator: 1 access cycle, response held until rsp_ready.
// Legal op: accept->rsp 1 edge later; illegal op: rsp at the accept edge; req_ready only in IDLE.
`ifndef LSU_DM_CODES
`define LSU_DM_CODES
`define DMRE_NOP 3'd0
`define DMRE_LB  3'd1
`define DMRE_LBU 3'd2
`define DMRE_LH  3'd3
`define DMRE_LHU 3'd4
`define DMRE_LW  3'd5
`define DMWR_NOP 2'd0
`define DMWR_SB  2'd1
`define DMWR_SH  2'd2
`define DMWR_SW  2'd3
`endif

module lsu_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  lsu_ctrl_if.slave        bus,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, nstate;
  logic              wr_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              err_r;
  logic              accept;
  logic              illegal;
  logic [ADDR_W:0]   span;
  logic [ADDR_W:0]   last_byte;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign accept = bus.req_valid && bus.req_ready;

  // The extra top bit of last_byte catches an access running past the top of memory.
  always_comb begin
    span = '0;
    case (bus.req_size)
      2'd1:    span = (ADDR_W+1)'(1);
      2'd2:    span = (ADDR_W+1)'(3);
      default: span = '0;
    endcase
    last_byte = {1'b0, bus.req_addr[ADDR_W-1:0]} + span;
    illegal = (bus.req_size == 2'd3)
           || (bus.req_size == 2'd1 && bus.req_addr[0])
           || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00)
           || (bus.req_addr[31:ADDR_W] != '0)
           || last_byte[ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = illegal ? RESP : ACCESS;
      ACCESS:  nstate = RESP;
      RESP:    if (bus.rsp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Strobes are gated by rstn so a reset landing in ACCESS cannot commit a write.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
    bus.dm_re     = `DMRE_NOP;
    bus.dm_wr     = `DMWR_NOP;
    if (state == ACCESS && rstn) begin
      if (wr_r) begin
        case (size_r)
          2'd0:    bus.dm_wr = `DMWR_SB;
          2'd1:    bus.dm_wr = `DMWR_SH;
          default: bus.dm_wr = `DMWR_SW;
        endcase
      end else begin
        case (size_r)
          2'd0:    bus.dm_re = uns_r ? `DMRE_LBU : `DMRE_LB;
          2'd1:    bus.dm_re = uns_r ? `DMRE_LHU : `DMRE_LH;
          default: bus.dm_re = `DMRE_LW;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_r      <= 1'b0;
      size_r    <= 2'd0;
      uns_r     <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      cnt_load  <= '0;
      cnt_store <= '0;
      cnt_err   <= '0;
    end else begin
      if (state == IDLE && accept) begin
        if (illegal) begin
          err_r   <= 1'b1;
          rdata_r <= '0;
          cnt_err <= sat_inc(cnt_err);
        end else begin
          wr_r    <= bus.req_wr;
          size_r  <= bus.req_size;
          uns_r   <= bus.req_unsigned;
          addr_r  <= bus.req_addr[ADDR_W-1:0];
          wdata_r <= bus.req_wdata;
        end
      end
      if (state == ACCESS) begin
        rdata_r <= wr_r ? 32'd0 : bus.dm_rdata;
        err_r   <= 1'b0;
        if (wr_r) cnt_store <= sat_inc(cnt_store);
        else      cnt_load  <= sat_inc(cnt_load);
      end
    end
  end

  assign bus.dm_addr   = addr_r;
  assign bus.dm_wdata  = wdata_r;
  assign bus.rsp_rdata = rdata_r;
  assign bus.rsp_err   = err_r;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator in the MEM stage: accepts one memory request at a time from the pipeline and drives the byte-addressed data memory's access port (address, read code, write code, write data). It checks alignment and range, sequences exactly one memory access cycle, registers the load result, and holds the response until the pipeline takes it. It also keeps saturating load, store and error counters for debug.

## Interface
- ADDR_W, 10: data-memory byte-address width. Addresses at or above 2^ADDR_W are out of range.
- CNT_W, 16: width of each statistics counter.

- clk  in  1  single clock. All state changes on posedge.
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  unit can accept a request. High only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word. 3 is illegal and flags an error.
- req_unsigned  in  1  zero-extend a load. Ignored for word loads and for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, little-endian. Low bytes are used.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  pipeline consumes the response.
- rsp_rdata  out  32  load result. 0 for stores and for errors.
- rsp_err  out  1  misaligned, out-of-range, or illegal-size request.
- dm_addr  out  ADDR_W  memory byte address.
- dm_re  out  3  read code, from the shared DMRE_* defines.
- dm_wr  out  2  write code, from the shared DMWR_* defines.
- dm_wdata  out  32  memory write data.
- dm_rdata  in  32  memory read data. Combinational and already extended by the memory.
- cnt_load, cnt_store, cnt_err  out  CNT_W each  saturating counters.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE → ACCESS: on req_valid && req_ready when the request is legal.
  - The latches capture op, size, unsigned, addr[ADDR_W-1:0] and wdata.
- IDLE → RESP: on an accepted illegal request.
  - Sets err_r = 1 and rdata_r = 0. Skips ACCESS, so no memory access occurs.
- A request is illegal if any of the following holds:
  - req_size == 3;
  - size half and addr[0] != 0;
  - size word and addr[1:0] != 0;
  - addr[31:ADDR_W] != 0;
  - addr + bytes − 1 ≥ 2^ADDR_W.
- ACCESS (exactly one cycle) → RESP.
  - Drive the decoded codes: dm_wr = SW/SH/SB for a store, or dm_re = LW/LH/LHU/LB/LBU for a load.
  - The memory commits the write on the negedge inside this cycle.
  - At the closing posedge, rdata_r <= dm_rdata for a load, or 0 for a store; err_r <= 0.
- RESP → IDLE: on rsp_ready. The pipeline must not assume a back-to-back accept.
- Outside ACCESS: dm_re = DMRE_NOP and dm_wr = DMWR_NOP. dm_addr and dm_wdata hold the latched values and never glitch.
- dm_re and dm_wr are combinationally forced to NOP while rstn = 0, so no write can land during a reset cycle.
- Counters: each is +1 when its RESP is entered. cnt_load and cnt_store count successful accesses only; cnt_err counts errors. Each saturates at all-ones.
- Reset: state IDLE. Latches, rdata_r, err_r and all counters are 0.

## Timing
- Reset values:
  - req_ready = 1 (once rstn is high);
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - dm_addr = 0, dm_wdata = 0;
  - dm_re = DMRE_NOP, dm_wr = DMWR_NOP;
  - cnt_* = 0.
- Legal request accepted at edge N:
  - ACCESS occupies cycle N..N+1;
  - rsp_valid is high from edge N+1;
  - minimum 3 cycles per request (IDLE, ACCESS, RESP).
- Illegal request accepted at edge N: rsp_valid is high from edge N, with rsp_err = 1.
- Handshake rules:
  - rsp_rdata and rsp_err are stable while rsp_valid && !rsp_ready.
  - req_* inputs are don't-care outside IDLE.
- rstn low at any edge forces IDLE and clears everything at that edge.
  - Reset during ACCESS: the write is suppressed (forced NOP) and the response is dropped.
  - Reset during RESP: the pending response is dropped.
- Simultaneous events:
  - rsp_ready asserted in the same cycle a new req_valid is presented: the request is not accepted in that cycle, because req_ready is 0 in RESP.
  - Counter increment at saturation keeps the value.

## Test plan
- Store/load word: SW addr 0x010, data 0xDEADBEEF → dm_wr = SW for exactly one cycle. Then LW 0x010 → rsp_rdata 0xDEADBEEF, rsp_valid 2 cycles after accept, cnt_store = 1, cnt_load = 1.
- Sub-word extension after the word above:
  - LB 0x013 → 0xFFFFFFDE;
  - LBU 0x013 → 0x000000DE;
  - LH 0x012 → 0xFFFFDEAD;
  - LHU 0x012 → 0x0000DEAD.
- Errors, each giving rsp_err = 1, rsp_rdata = 0, rsp_valid 1 cycle after accept, dm_wr/dm_re NOP throughout:
  - LW 0x011 (misaligned);
  - SH 0x3FF (misaligned);
  - SW 0x400 (out of range);
  - size 3 (illegal).
  - Expected cnt_err = 4, and memory unchanged: a following LW 0x3FC returns its prior value.
- Backpressure: hold rsp_ready = 0 for 5 cycles after a load response → rsp_valid, rsp_rdata and rsp_err stable and req_ready = 0. Release → IDLE next edge.
- Reset mid-op: rstn low in the ACCESS cycle of SB 0x020, data 0x55 → no memory write (a later LBU 0x020 returns the pre-test value), all outputs at reset values, counters 0.
- Saturation: with CNT_W = 2, issue 5 loads → cnt_load stays 3.
